// File: rtl/fpgc_reset_pkg.sv
// Types shared by the FPGC4 reset sequencer: sequence states and reset-cause codes.
package fpgc_reset_pkg;

    typedef enum logic [1:0] {
        HOLD_EXT,
        HOLD_SYS,
        RUN
    } seq_state_e;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'b00,
        CAUSE_BTN = 2'b01,
        CAUSE_DTR = 2'b10,
        CAUSE_WDT = 2'b11
    } reset_cause_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_debouncer.sv
// Synchroniser plus stable-count debouncer; `rise` is a same-cycle strobe for the
// debounced level going 0->1 (raw input treated as active-high).
module reset_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1
) (
    input  logic clk,
    input  logic nreset,
    input  logic raw,
    output logic sample,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       stable_cnt;
    logic                   settle;

    assign sample = sync_q[SYNC_STAGES-1];
    // The Nth consecutive differing sample flips the level on this edge.
    assign settle = (sample != level) && (stable_cnt == CNT_LAST);
    assign rise   = settle && sample;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q     <= '0;
            stable_cnt <= '0;
            level      <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (sample == level) begin
                stable_cnt <= '0;
            end else if (settle) begin
                level      <= sample;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// FPGC4 central reset source: ordered ext/sys reset release after POR, button or DTR.
// Optional watchdog trigger enabled by defining RSTSEQ_WATCHDOG_EN.
module reset_sequencer
    import fpgc_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned EXT_HOLD_CYCLES = 25000,
    parameter int unsigned SYS_HOLD_CYCLES = 1024,
    parameter int unsigned WDT_CYCLES      = 50000000
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       btn_n,
    input  logic       dtr,
    input  logic       wdt_kick,
    output logic       sys_reset,
    output logic       ext_reset,
    output logic       ext_nreset,
    output logic       dtr_level,
    output logic [1:0] reset_cause
);

    localparam int unsigned CNT_W = $clog2(max_u(EXT_HOLD_CYCLES, SYS_HOLD_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] EXT_LAST = CNT_W'(EXT_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYS_LAST = CNT_W'(SYS_HOLD_CYCLES - 1);

    seq_state_e   state;
    logic [CNT_W-1:0] cnt;
    logic         btn_rise, dtr_rise, wdt_fire, trigger;
    reset_cause_e trig_cause;
    logic         btn_sample, btn_level, dtr_settled;
    logic         unused_sigs;

    // Button is inverted ahead of the synchroniser so a cleared chain reads "not pressed".
    reset_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk   (clk),
        .nreset(nreset),
        .raw   (~btn_n),
        .sample(btn_sample),
        .level (btn_level),
        .rise  (btn_rise)
    );

    reset_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(1)
    ) u_dtr (
        .clk   (clk),
        .nreset(nreset),
        .raw   (dtr),
        .sample(dtr_level),
        .level (dtr_settled),
        .rise  (dtr_rise)
    );

`ifdef RSTSEQ_WATCHDOG_EN
    localparam int unsigned WDT_W = $clog2(WDT_CYCLES) + 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wdt_cnt <= '0;
        end else if (state != RUN || wdt_kick || trigger) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end

    assign wdt_fire    = (state == RUN) && (wdt_cnt == WDT_LAST) && !wdt_kick;
    assign unused_sigs = ^{btn_sample, btn_level, dtr_settled};
`else
    assign wdt_fire    = 1'b0;
    assign unused_sigs = ^{btn_sample, btn_level, dtr_settled, wdt_kick, (WDT_CYCLES != 0)};
`endif

    always_comb begin
        trigger    = 1'b1;
        trig_cause = CAUSE_POR;
        if (wdt_fire)      trig_cause = CAUSE_WDT;
        else if (btn_rise) trig_cause = CAUSE_BTN;
        else if (dtr_rise) trig_cause = CAUSE_DTR;
        else               trigger    = 1'b0;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= HOLD_EXT;
            cnt         <= '0;
            sys_reset   <= 1'b1;
            ext_reset   <= 1'b1;
            reset_cause <= CAUSE_POR;
        end else if (trigger) begin
            state       <= HOLD_EXT;
            cnt         <= '0;
            sys_reset   <= 1'b1;
            ext_reset   <= 1'b1;
            reset_cause <= trig_cause;
        end else begin
            case (state)
                HOLD_EXT: begin
                    if (cnt == EXT_LAST) begin
                        state     <= HOLD_SYS;
                        cnt       <= '0;
                        ext_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD_SYS: begin
                    if (cnt == SYS_LAST) begin
                        state     <= RUN;
                        cnt       <= '0;
                        sys_reset <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN:     cnt <= '0;
                default: state <= HOLD_EXT;
            endcase
        end
    end

    assign ext_nreset = ~ext_reset;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: per-cycle expected outputs from a timeline model,
// plus directed checks of sequence lengths, latencies and causes.
module tb_reset_sequencer;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 5;
    localparam int unsigned EXT  = 8;
    localparam int unsigned SYS  = 4;
    localparam int unsigned WDT  = 20;

    typedef struct packed {
        logic       sys;
        logic       ext;
        logic       ext_n;
        logic       dl;
        logic [1:0] cause;
    } obs_t;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       btn_n = 1'b1;
    logic       dtr = 1'b0;
    logic       wdt_kick = 1'b0;
    logic       sys_reset, ext_reset, ext_nreset, dtr_level;
    logic [1:0] reset_cause;

    int   checks = 0;
    int   passes = 0;
    int   ext_rises = 0;
    int   cyc = 0;
    int   kick_mode = 1;
    int   kick_ph = 0;
    logic ext_prev = 1'b1;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    reset_sequencer #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .EXT_HOLD_CYCLES(EXT),
        .SYS_HOLD_CYCLES(SYS),
        .WDT_CYCLES     (WDT)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .btn_n      (btn_n),
        .dtr        (dtr),
        .wdt_kick   (wdt_kick),
        .sys_reset  (sys_reset),
        .ext_reset  (ext_reset),
        .ext_nreset (ext_nreset),
        .dtr_level  (dtr_level),
        .reset_cause(reset_cause)
    );

    // Reference model: time since the last sequence start, raw-input histories, run lengths.
    logic       btn_h [0:SYNC];
    logic       dtr_h [0:SYNC];
    int         m_t, low_run, high_run, wdt_idle;
    logic       m_pressed;
    logic [1:0] m_cause;
    logic       in_run, b_trig, d_trig, w_trig;
    obs_t       m_exp;

    always @(posedge clk) begin
        if (!nreset) begin
            for (int i = 0; i <= int'(SYNC); i++) begin
                btn_h[i] = 1'b1;
                dtr_h[i] = 1'b0;
            end
            m_t = 0; low_run = 0; high_run = 0; wdt_idle = 0;
            m_pressed = 1'b0;
            m_cause = 2'b00;
            m_exp = {1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        end else begin
            in_run = (m_t >= int'(EXT + SYS));
            b_trig = !m_pressed && (low_run == int'(DEB));
            d_trig = dtr_h[SYNC-1] && !dtr_h[SYNC];
            w_trig = 1'b0;
`ifdef RSTSEQ_WATCHDOG_EN
            w_trig = in_run && (wdt_idle == int'(WDT) - 1) && !wdt_kick;
`endif
            if (w_trig || b_trig || d_trig) begin
                m_t = 0;
                m_cause = w_trig ? 2'b11 : (b_trig ? 2'b01 : 2'b10);
            end else if (m_t < int'(EXT + SYS)) begin
                m_t++;
            end
            if (!in_run || wdt_kick || w_trig || b_trig || d_trig) wdt_idle = 0;
            else wdt_idle++;
            if (b_trig) m_pressed = 1'b1;
            else if (m_pressed && high_run == int'(DEB)) m_pressed = 1'b0;
            for (int i = SYNC; i > 0; i--) begin
                btn_h[i] = btn_h[i-1];
                dtr_h[i] = dtr_h[i-1];
            end
            btn_h[0] = btn_n;
            dtr_h[0] = dtr;
            if (!btn_h[SYNC-1]) begin low_run++; high_run = 0; end
            else begin high_run++; low_run = 0; end
            m_exp.ext   = (m_t < int'(EXT));
            m_exp.sys   = (m_t < int'(EXT + SYS));
            m_exp.ext_n = !m_exp.ext;
            m_exp.dl    = dtr_h[SYNC-1];
            m_exp.cause = m_cause;
        end
        exp_q.push_back(m_exp);
    end

    // Monitor: pops one expected entry per clock and compares it with the DUT outputs.
    initial begin : monitor
        obs_t e, g;
        forever begin
            @(posedge clk);
            #2;
            g = {sys_reset, ext_reset, ext_nreset, dtr_level, reset_cause};
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard cycle %0d: no expected entry queued", cyc);
            end else begin
                e = exp_q.pop_front();
                if (g === e) passes++;
                else $display("FAIL outputs cycle %0d: got sys=%b ext=%b ext_n=%b dtr_level=%b cause=%b, expected sys=%b ext=%b ext_n=%b dtr_level=%b cause=%b",
                              cyc, g.sys, g.ext, g.ext_n, g.dl, g.cause, e.sys, e.ext, e.ext_n, e.dl, e.cause);
            end
            if (ext_reset && !ext_prev) ext_rises++;
            ext_prev = ext_reset;
            cyc++;
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    task automatic set_kick(input int mode);
        kick_mode = mode;
        kick_ph   = 0;
        wdt_kick  = (mode == 1);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            case (kick_mode)
                0:       wdt_kick = 1'b0;
                1:       wdt_kick = 1'b1;
                2:       begin wdt_kick = (kick_ph % 15 == 0); kick_ph++; end
                default: wdt_kick = ($urandom_range(0, 24) == 0);
            endcase
        end
    endtask

    // Edges until ext_reset reads `val`; -1 if the bound expires.
    task automatic wait_ext(input logic val, output int n);
        int k = 0;
        n = -1;
        while (k < 300 && n < 0) begin
            @(posedge clk);
            #2;
            k++;
            if (ext_reset == val) n = k;
        end
    endtask

    // Called just after a sequence start edge: edges until ext and sys release.
    task automatic measure(output int ne, output int ns);
        int k = 0;
        ne = -1;
        ns = -1;
        while (k < 300 && ns < 0) begin
            @(posedge clk);
            #2;
            k++;
            if (ne < 0 && !ext_reset) ne = k;
            if (!sys_reset) ns = k;
        end
    endtask

    initial begin : stim
        int n, ne, ns, r0, btn_left;
        set_kick(1);
        step(3);
        check("por_sys_reset", int'(sys_reset), 1);
        check("por_ext_reset", int'(ext_reset), 1);
        check("por_ext_nreset", int'(ext_nreset), 0);
        check("por_dtr_level", int'(dtr_level), 0);
        check("por_cause", int'(reset_cause), 0);
        nreset = 1'b1;
        measure(ne, ns);
        check("por_ext_len", ne, int'(EXT));
        check("por_sys_len", ns, int'(EXT + SYS));
        check("por_cause_after", int'(reset_cause), 0);

        // Short button glitch, then a long press.
        step(5);
        r0 = ext_rises;
        btn_n = 1'b0; step(4); btn_n = 1'b1; step(20);
        check("btn_short_no_seq", ext_rises, r0);
        btn_n = 1'b0; step(50); btn_n = 1'b1; step(30);
        check("btn_long_one_seq", ext_rises, r0 + 1);
        check("btn_cause", int'(reset_cause), 1);

        // DTR rising edge, then falling edge.
        dtr = 1'b1;
        wait_ext(1'b1, n);
        check("dtr_latency", n, int'(SYNC) + 1);
        check("dtr_cause", int'(reset_cause), 2);
        check("dtr_level_high", int'(dtr_level), 1);
        measure(ne, ns);
        check("dtr_ext_len", ne, int'(EXT));
        check("dtr_sys_len", ns, int'(EXT + SYS));
        step(1);
        r0 = ext_rises;
        dtr = 1'b0; step(20);
        check("dtr_fall_no_seq", ext_rises, r0);
        check("dtr_level_low", int'(dtr_level), 0);

        // DTR rise landing in HOLD_SYS cycle 2 restarts the whole sequence.
        dtr = 1'b1;
        wait_ext(1'b1, n);
        step(1); dtr = 1'b0;
        wait_ext(1'b0, n);
        step(1); dtr = 1'b1;
        wait_ext(1'b1, n);
        check("retrig_latency", n, int'(SYNC) + 1);
        measure(ne, ns);
        check("retrig_ext_len", ne, int'(EXT));
        check("retrig_sys_len", ns, int'(EXT + SYS));
        check("retrig_rises", ext_rises, r0 + 2);

        // Button debounce completes on the same cycle as a DTR edge.
        step(1); dtr = 1'b0; step(30);
        r0 = ext_rises;
        btn_n = 1'b0; step(4); dtr = 1'b1;
        wait_ext(1'b1, n);
        check("coincide_latency", n, int'(SYNC) + 1);
        check("coincide_cause", int'(reset_cause), 1);
        step(50); btn_n = 1'b1; step(30);
        check("coincide_one_seq", ext_rises, r0 + 1);
        dtr = 1'b0; step(20);

`ifdef RSTSEQ_WATCHDOG_EN
        set_kick(0);
        wait_ext(1'b1, n);
        check("wdt_timeout", n, int'(WDT));
        check("wdt_cause", int'(reset_cause), 3);
        step(1);
        set_kick(2);
        measure(ne, ns);
        check("wdt_sys_len", ns, int'(EXT + SYS));
        r0 = ext_rises;
        step(200);
        check("wdt_kicked_no_seq", ext_rises, r0);
        check("wdt_kicked_ext_low", int'(ext_reset), 0);
        set_kick(1);
`endif

        // Randomised phase: button bursts, DTR toggles, random kicks, rare power-on resets.
        set_kick(3);
        btn_left = 0;
        for (int c = 0; c < 2000; c++) begin
            step(1);
            if (btn_left == 0) begin
                btn_n    = 1'($urandom_range(0, 1));
                btn_left = $urandom_range(1, 12);
            end
            btn_left--;
            if ($urandom_range(0, 19) == 0) dtr = ~dtr;
            if (!nreset) nreset = 1'b1;
            else if ($urandom_range(0, 399) == 0) nreset = 1'b0;
        end
        nreset = 1'b1;
        set_kick(1);
        step(40);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
